// File: rtl/mcu_pkg.sv
// Shared types and constants for the multi-cycle control unit.
package mcu_pkg;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4
   } state_t;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;

   localparam int unsigned DEF_OPCODE_W = 6;
   localparam logic [5:0]  DEF_OP_LOAD   = 6'b001100;
   localparam logic [5:0]  DEF_OP_STORE  = 6'b001101;
   localparam logic [5:0]  DEF_OP_BRANCH = 6'b001110;
   localparam logic [5:0]  DEF_OP_JUMP   = 6'b010000;

endpackage

// File: rtl/multicycle_control_unit_mem_timer.sv
// Data-memory wait counter; expire_c flags the LIMIT-th consecutive non-ready cycle.
module mcu_mem_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expire_c
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_q;

   assign expire_c = enable && (count_q == CW'(LIMIT - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + CW'(1);
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK controller with stall, memory timeout
// and retired-instruction counter. Define MCU_ILLEGAL_OPCODE_EN to add illegal_opcode trapping.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int unsigned          OPCODE_W    = DEF_OPCODE_W,
   parameter logic [OPCODE_W-1:0]  OP_LOAD     = OPCODE_W'(DEF_OP_LOAD),
   parameter logic [OPCODE_W-1:0]  OP_STORE    = OPCODE_W'(DEF_OP_STORE),
   parameter logic [OPCODE_W-1:0]  OP_BRANCH   = OPCODE_W'(DEF_OP_BRANCH),
   parameter logic [OPCODE_W-1:0]  OP_JUMP     = OPCODE_W'(DEF_OP_JUMP),
   parameter int unsigned          MEM_TIMEOUT = 16,
   parameter int unsigned          CNT_W       = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                imem_ready,
   input  logic                dmem_ready,
   input  logic                branch_taken,
   input  logic                stall,
   output logic                imem_req,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                reg_mem_write_enable,
   output logic                reg_mem_regmux_control,
   output logic                reg_mem_writemux_control,
   output logic                alu_mux_control,
   output logic                data_mem_write,
   output logic                data_mem_read_enable,
   output logic                branch_enable,
   output logic                jump_enable,
   output logic                mem_error,
   output logic [CNT_W-1:0]    retired_count,
   output logic [2:0]          state_o
`ifdef MCU_ILLEGAL_OPCODE_EN
   ,
   output logic                illegal_opcode
`endif
);

   state_t              state_q;
   state_t              state_d;
   logic [OPCODE_W-1:0] opcode_q;
   logic                retire;
   logic                mem_wait;
   logic                mem_expire_c;
   logic                is_load;
   logic                is_store;
   logic                is_branch;
   logic                is_jump;

   assign is_load   = (opcode_q == OP_LOAD);
   assign is_store  = (opcode_q == OP_STORE);
   assign is_branch = (opcode_q == OP_BRANCH);
   assign is_jump   = (opcode_q == OP_JUMP);
   assign state_o   = state_q;

`ifdef MCU_ILLEGAL_OPCODE_EN
   logic is_legal;
   assign is_legal = (opcode_q == '0) || is_load || is_store || is_branch || is_jump;
`endif

   // Timer only advances on live, non-ready MEM cycles and restarts on every MEM entry.
   assign mem_wait = (state_q == MEM) && !stall && !dmem_ready;

   mcu_mem_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_mem_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (state_q != MEM),
      .enable   (mem_wait),
      .expire_c (mem_expire_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= FETCH;
         opcode_q      <= '0;
         retired_count <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == DECODE && !stall) begin
            opcode_q <= opcode;
         end
         if (retire) begin
            retired_count <= retired_count + CNT_W'(1);
         end
      end
   end

   // Next state and control decode; everything is held low while reset is asserted.
   always_comb begin
      state_d                  = state_q;
      imem_req                 = 1'b0;
      ir_write                 = 1'b0;
      pc_write                 = 1'b0;
      pc_src                   = PC_SEQ;
      reg_mem_write_enable     = 1'b0;
      reg_mem_regmux_control   = 1'b0;
      reg_mem_writemux_control = 1'b0;
      alu_mux_control          = 1'b0;
      data_mem_write           = 1'b0;
      data_mem_read_enable     = 1'b0;
      branch_enable            = 1'b0;
      jump_enable              = 1'b0;
      mem_error                = 1'b0;
      retire                   = 1'b0;
`ifdef MCU_ILLEGAL_OPCODE_EN
      illegal_opcode           = 1'b0;
`endif
      if (reset_n) begin
         unique case (state_q)
            FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_write = 1'b1;
                  state_d  = DECODE;
               end
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
               alu_mux_control = is_load || is_store;
               if (is_branch) begin
                  branch_enable = 1'b1;
                  pc_write      = 1'b1;
                  pc_src        = branch_taken ? PC_BR : PC_SEQ;
                  retire        = 1'b1;
                  state_d       = FETCH;
               end else if (is_jump) begin
                  jump_enable = 1'b1;
                  pc_write    = 1'b1;
                  pc_src      = PC_JMP;
                  retire      = 1'b1;
                  state_d     = FETCH;
               end else if (is_load || is_store) begin
                  state_d = MEM;
`ifdef MCU_ILLEGAL_OPCODE_EN
               end else if (!is_legal) begin
                  illegal_opcode = 1'b1;
                  pc_write       = 1'b1;
                  state_d        = FETCH;
`endif
               end else begin
                  state_d = WRITEBACK;
               end
            end
            MEM: begin
               alu_mux_control      = 1'b1;
               data_mem_read_enable = is_load;
               data_mem_write       = is_store;
               if (dmem_ready) begin
                  if (is_load) begin
                     state_d = WRITEBACK;
                  end else begin
                     pc_write = 1'b1;
                     retire   = 1'b1;
                     state_d  = FETCH;
                  end
               end else if (mem_expire_c) begin
                  mem_error = 1'b1;
                  pc_write  = 1'b1;
                  state_d   = FETCH;
               end
            end
            WRITEBACK: begin
               reg_mem_write_enable     = 1'b1;
               reg_mem_regmux_control   = !is_load;
               reg_mem_writemux_control = is_load;
               pc_write                 = 1'b1;
               retire                   = 1'b1;
               state_d                  = FETCH;
            end
            default: state_d = FETCH;
         endcase

         // Stall freezes progress and suppresses every side-effecting strobe.
         if (stall) begin
            state_d              = state_q;
            ir_write             = 1'b0;
            pc_write             = 1'b0;
            reg_mem_write_enable = 1'b0;
            data_mem_write       = 1'b0;
            mem_error            = 1'b0;
            retire               = 1'b0;
`ifdef MCU_ILLEGAL_OPCODE_EN
            illegal_opcode       = 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction trace versus a sequence model.
module tb_multicycle_control_unit;

   localparam int unsigned TO     = 16;
   localparam logic [5:0]  OP_LD  = 6'b001100;
   localparam logic [5:0]  OP_ST  = 6'b001101;
   localparam logic [5:0]  OP_BR  = 6'b001110;
   localparam logic [5:0]  OP_JMP = 6'b010000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [5:0]  opcode;
   logic        imem_ready;
   logic        dmem_ready;
   logic        branch_taken;
   logic        stall;
   logic        imem_req;
   logic        ir_write;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        reg_mem_write_enable;
   logic        reg_mem_regmux_control;
   logic        reg_mem_writemux_control;
   logic        alu_mux_control;
   logic        data_mem_write;
   logic        data_mem_read_enable;
   logic        branch_enable;
   logic        jump_enable;
   logic        mem_error;
   logic [31:0] retired_count;
   logic [2:0]  state_o;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_retired = '0;

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .opcode                   (opcode),
      .imem_ready               (imem_ready),
      .dmem_ready               (dmem_ready),
      .branch_taken             (branch_taken),
      .stall                    (stall),
      .imem_req                 (imem_req),
      .ir_write                 (ir_write),
      .pc_write                 (pc_write),
      .pc_src                   (pc_src),
      .reg_mem_write_enable     (reg_mem_write_enable),
      .reg_mem_regmux_control   (reg_mem_regmux_control),
      .reg_mem_writemux_control (reg_mem_writemux_control),
      .alu_mux_control          (alu_mux_control),
      .data_mem_write           (data_mem_write),
      .data_mem_read_enable     (data_mem_read_enable),
      .branch_enable            (branch_enable),
      .jump_enable              (jump_enable),
      .mem_error                (mem_error),
      .retired_count            (retired_count),
      .state_o                  (state_o)
   );

   // Runs one instruction from FETCH until the next FETCH, then compares the observed trace with
   // the expected state walk: iw = FETCH wait cycles, dw = non-ready MEM cycles before dmem_ready.
   task automatic run_instr(input logic [5:0] op, input logic taken, input int iw, input int dw,
                            input int stall_pct, input int stall_at, input int stall_len,
                            input string name);
      int exp_seq[$];
      int got_seq[$];
      bit ld, st, br, jp, rt, tmo, stl, left, seq_ok;
      int m, s, want_we, want_pcs;
      int fetch_n = 0, mem_n = 0, forced = 0, cyc = 0;
      int n_ir = 0, n_pcw = 0, n_we = 0, n_rd = 0, n_wr = 0, n_err = 0;
      int n_br = 0, n_jp = 0, n_alu = 0, n_req = 0, n_bad = 0;
      int pcs = -1, rmux = -1, wmux = -1;
      ld  = (op == OP_LD);
      st  = (op == OP_ST);
      br  = (op == OP_BR);
      jp  = (op == OP_JMP);
      rt  = !(ld || st || br || jp);
      tmo = (ld || st) && (dw >= int'(TO));
      m   = tmo ? int'(TO) : dw + 1;
      for (int i = 0; i <= iw; i++) exp_seq.push_back(0);
      exp_seq.push_back(1);
      exp_seq.push_back(2);
      if (ld || st) for (int i = 0; i < m; i++) exp_seq.push_back(3);
      if (rt || (ld && !tmo)) exp_seq.push_back(4);
      want_we  = (rt || (ld && !tmo)) ? 1 : 0;
      want_pcs = br ? (taken ? 1 : 0) : (jp ? 2 : 0);
      left     = 1'b0;

      while (1) begin
         s = int'(state_o);
         if (s == 0 && left) break;
         if (cyc >= 200) begin
            checks++; errors++;
            $display("FAIL %s progress: state %0d after %0d cycles, want return to FETCH", name, s, cyc);
            break;
         end
         if (s != 0) left = 1'b1;
         stl = 1'b0;
         if (s == 3 && mem_n == stall_at && forced < stall_len) begin
            stl = 1'b1;
            forced++;
         end else if (stall_pct > 0 && int'($urandom_range(99, 0)) < stall_pct) begin
            stl = 1'b1;
         end
         stall        = stl;
         imem_ready   = (s == 0) ? (fetch_n >= iw) : 1'($urandom);
         dmem_ready   = (s == 3) ? (mem_n >= dw) : 1'($urandom);
         opcode       = (s <= 1) ? op : 6'($urandom);
         branch_taken = (s == 2) ? taken : 1'($urandom);
         if (!stl) begin
            got_seq.push_back(s);
            if (s == 0) fetch_n++;
            if (s == 3) mem_n++;
         end
         @(negedge clk);
         if (stl) begin
            if (ir_write !== 1'b0 || pc_write !== 1'b0 || reg_mem_write_enable !== 1'b0 ||
                data_mem_write !== 1'b0 || mem_error !== 1'b0) n_bad++;
            if (imem_req !== (s == 0) || data_mem_read_enable !== (s == 3 && ld)) n_bad++;
         end else begin
            if (ir_write === 1'b1) n_ir++;
            if (pc_write === 1'b1) begin n_pcw++; pcs = int'(pc_src); end
            if (reg_mem_write_enable === 1'b1) begin
               n_we++;
               rmux = int'(reg_mem_regmux_control);
               wmux = int'(reg_mem_writemux_control);
            end
            if (data_mem_read_enable === 1'b1) n_rd++;
            if (data_mem_write === 1'b1) n_wr++;
            if (mem_error === 1'b1) n_err++;
            if (branch_enable === 1'b1) n_br++;
            if (jump_enable === 1'b1) n_jp++;
            if (alu_mux_control === 1'b1) n_alu++;
            if (imem_req === 1'b1) n_req++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      stall = 1'b0;
      if (!tmo) exp_retired = exp_retired + 32'd1;

      seq_ok = (got_seq.size() == exp_seq.size());
      if (seq_ok) for (int i = 0; i < exp_seq.size(); i++) if (got_seq[i] != exp_seq[i]) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin
         errors++;
         $display("FAIL %s state_walk: got %0d live cycles, want %0d", name, got_seq.size(), exp_seq.size());
      end
      checks++; if (n_ir != 1) begin errors++; $display("FAIL %s ir_write: got %0d want 1", name, n_ir); end
      checks++; if (n_pcw != 1) begin errors++; $display("FAIL %s pc_write: got %0d want 1", name, n_pcw); end
      checks++; if (pcs != want_pcs) begin errors++; $display("FAIL %s pc_src: got %0d want %0d", name, pcs, want_pcs); end
      checks++; if (n_we != want_we) begin errors++; $display("FAIL %s reg_write: got %0d want %0d", name, n_we, want_we); end
      if (want_we == 1) begin
         checks++;
         if (rmux != (rt ? 1 : 0) || wmux != (ld ? 1 : 0)) begin
            errors++;
            $display("FAIL %s wb_mux: got regmux=%0d writemux=%0d want %0d/%0d", name, rmux, wmux, rt, ld);
         end
      end
      checks++; if (n_rd != (ld ? m : 0)) begin errors++; $display("FAIL %s mem_read: got %0d want %0d", name, n_rd, ld ? m : 0); end
      checks++; if (n_wr != (st ? m : 0)) begin errors++; $display("FAIL %s mem_write: got %0d want %0d", name, n_wr, st ? m : 0); end
      checks++; if (n_err != (tmo ? 1 : 0)) begin errors++; $display("FAIL %s mem_error: got %0d want %0d", name, n_err, tmo); end
      checks++; if (n_br != (br ? 1 : 0)) begin errors++; $display("FAIL %s branch_enable: got %0d want %0d", name, n_br, br); end
      checks++; if (n_jp != (jp ? 1 : 0)) begin errors++; $display("FAIL %s jump_enable: got %0d want %0d", name, n_jp, jp); end
      checks++; if (n_alu != ((ld || st) ? m + 1 : 0)) begin errors++; $display("FAIL %s alu_mux: got %0d want %0d", name, n_alu, (ld || st) ? m + 1 : 0); end
      checks++; if (n_req != iw + 1) begin errors++; $display("FAIL %s imem_req: got %0d want %0d", name, n_req, iw + 1); end
      checks++; if (n_bad != 0) begin errors++; $display("FAIL %s stall_strobes: got %0d bad cycles want 0", name, n_bad); end
      checks++; if (retired_count !== exp_retired) begin errors++; $display("FAIL %s retired_count: got %0d want %0d", name, retired_count, exp_retired); end
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      stall        = 1'b0;
      opcode       = '0;
      imem_ready   = 1'b1;
      dmem_ready   = 1'b1;
      branch_taken = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset state: got %0d want 0", state_o); end
      checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset retired: got %0d want 0", retired_count); end
      checks++;
      if ({imem_req, ir_write, pc_write, pc_src, reg_mem_write_enable, reg_mem_regmux_control,
           reg_mem_writemux_control, alu_mux_control, data_mem_write, data_mem_read_enable,
           branch_enable, jump_enable, mem_error} !== 14'd0) begin
         errors++;
         $display("FAIL reset outputs: got imem_req=%0d ir_write=%0d pc_write=%0d, want all 0", imem_req, ir_write, pc_write);
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      reset_n    = 1'b1;
      @(posedge clk);
      #1;
      exp_retired = '0;
   endtask

   task automatic test_rtype();
      run_instr(6'b000000, 1'b0, 0, 0, 0, -1, 0, "rtype");
      run_instr(6'b100011, 1'b1, 2, 0, 0, -1, 0, "rtype_other");
   endtask

   task automatic test_load();
      run_instr(OP_LD, 1'b0, 0, 2, 0, -1, 0, "load");
      run_instr(OP_LD, 1'b0, 1, 0, 0, -1, 0, "load_fast");
   endtask

   task automatic test_branch_jump();
      run_instr(OP_BR, 1'b1, 0, 0, 0, -1, 0, "branch_taken");
      run_instr(OP_BR, 1'b0, 0, 0, 0, -1, 0, "branch_not_taken");
      run_instr(OP_JMP, 1'b0, 0, 0, 0, -1, 0, "jump");
   endtask

   task automatic test_timeout();
      run_instr(OP_ST, 1'b0, 0, 1000, 0, -1, 0, "store_timeout");
      run_instr(OP_ST, 1'b0, 0, TO - 1, 0, -1, 0, "store_ready_at_limit");
      run_instr(OP_LD, 1'b0, 0, TO, 0, -1, 0, "load_timeout");
      run_instr(OP_ST, 1'b0, 0, 0, 0, -1, 0, "store_fast");
   endtask

   task automatic test_stall();
      run_instr(OP_LD, 1'b0, 0, 2, 0, 2, 5, "load_stall_mem");
      run_instr(OP_ST, 1'b0, 0, 4, 0, 1, 3, "store_stall_mem");
   endtask

   task automatic test_random();
      logic [5:0] op;
      int         pick;
      for (int i = 0; i < 40; i++) begin
         pick = int'($urandom_range(4, 0));
         case (pick)
            0: op = OP_LD;
            1: op = OP_ST;
            2: op = OP_BR;
            3: op = OP_JMP;
            default: op = 6'($urandom);
         endcase
         run_instr(op, 1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(20, 0)),
                   20, -1, 0, $sformatf("rand%0d_op%0h", i, op));
      end
   endtask

   task automatic test_reset_mid();
      stall      = 1'b0;
      opcode     = 6'b000000;
      imem_ready = 1'b1;
      dmem_ready = 1'b0;
      for (int i = 0; i < 20 && state_o != 3'd4; i++) begin
         @(posedge clk);
         #1;
      end
      checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL reset_mid reach_wb: got state %0d want 4", state_o); end
      reset_n = 1'b0;
      #1;
      checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_mid state: got %0d want 0", state_o); end
      checks++; if (retired_count !== 32'd0) begin errors++; $display("FAIL reset_mid retired: got %0d want 0", retired_count); end
      checks++;
      if ({imem_req, ir_write, pc_write, pc_src, reg_mem_write_enable, reg_mem_regmux_control,
           reg_mem_writemux_control, alu_mux_control, data_mem_write, data_mem_read_enable,
           branch_enable, jump_enable, mem_error} !== 14'd0) begin
         errors++;
         $display("FAIL reset_mid outputs: got reg_we=%0d pc_write=%0d imem_req=%0d, want all 0", reg_mem_write_enable, pc_write, imem_req);
      end
      exp_retired = '0;
      @(negedge clk);
      imem_ready = 1'b0;
      reset_n    = 1'b1;
      @(posedge clk);
      #1;
      run_instr(6'b000000, 1'b0, 0, 0, 0, -1, 0, "rtype_after_reset");
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load();
      test_branch_jump();
      test_timeout();
      test_stall();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
